// File: rtl/mux8_to_1.sv
// Eight-way data selector with a combinational output and a one-cycle registered copy.
// The select path is a one-hot decode feeding an AND-OR tree, so unknown selects or data surface as X.
module mux8_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] i7,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i0,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q
);

    logic [2:0] sel;
    logic [7:0] dec;

    assign sel = {s2, s1, s0};

    for (genvar k = 0; k < 8; k++) begin : g_dec
        assign dec[k] = (sel == 3'(k));
    end

    // Masking with the decoded line rather than a case keeps X on sel visible on z.
    function automatic logic [WIDTH-1:0] gate(input logic en, input logic [WIDTH-1:0] d);
        return {WIDTH{en}} & d;
    endfunction

    always_comb begin
        z = gate(dec[0], i0) | gate(dec[1], i1) | gate(dec[2], i2) | gate(dec[3], i3)
          | gate(dec[4], i4) | gate(dec[5], i5) | gate(dec[6], i6) | gate(dec[7], i7);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= '0;
        end else begin
            z_q <= z;
        end
    end

endmodule

// File: tb/tb_mux8_to_1.sv
// Self-checking bench for mux8_to_1: array-indexed reference model plus directed literal checks.
module tb_mux8_to_1;
    localparam int W = 4;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] ZERO = '0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   sel;
    logic [W-1:0] d [8];
    logic [W-1:0] z, z_q;

    logic [W-1:0] exp_q;
    logic         qvalid = 1'b0;
    logic         run = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    mux8_to_1 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
        .i7(d[7]), .i6(d[6]), .i5(d[5]), .i4(d[4]),
        .i3(d[3]), .i2(d[2]), .i1(d[1]), .i0(d[0]),
        .z(z), .z_q(z_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_data();
        for (int k = 0; k < 8; k++) d[k] = ZERO;
    endtask

    // Reference: the registered output is the selected word seen at the edge, or zero under reset.
    always @(posedge clk) begin
        exp_q  <= rst_n ? d[sel] : ZERO;
        qvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (run) begin
            check("z_cycle", z, d[sel]);
            if (qvalid) check("zq_cycle", z_q, exp_q);
        end
    end

    initial begin
        rst_n = 1'b0;
        sel   = 3'd0;
        clear_data();
        run   = 1'b1;

        step();
        step();
        check("reset_zq", z_q, ZERO);
        check("reset_z", z, ZERO);

        rst_n = 1'b1;
        step();
        check("zero_zq", z_q, ZERO);

        d[2] = ONES; d[4] = ONES; d[5] = ONES;
        sel = 3'b010;
        #1 check("sel2_z", z, ONES);
        step();
        check("sel2_zq", z_q, ONES);

        sel = 3'b011;
        #1 check("sel3_z", z, ZERO);
        check("sel3_zq_hold", z_q, ONES);
        step();
        check("sel3_zq", z_q, ZERO);

        sel = 3'b111;
        #1 check("sel7_z", z, ZERO);
        sel = 3'b101;
        #1 check("sel5_z", z, ONES);
        d[5] = ZERO;
        #1 check("sel5_data_z", z, ZERO);
        step();

        for (int h = 0; h < 8; h++) begin
            clear_data();
            d[h] = ONES;
            for (int s = 0; s < 8; s++) begin
                sel = 3'(s);
                #1 check("walk_z", z, (s == h) ? ONES : ZERO);
                step();
                check("walk_zq", z_q, (s == h) ? ONES : ZERO);
            end
        end

        clear_data();
        d[0] = ONES;
        sel = 3'b000;
        step();
        check("pre_rst_zq", z_q, ONES);
        rst_n = 1'b0;
        step();
        check("mid_rst_zq", z_q, ZERO);
        check("mid_rst_z", z, ONES);
        rst_n = 1'b1;
        step();
        check("post_rst_zq", z_q, ONES);

        d[3] = 4'b1010; d[6] = 4'b0110;
        sel = 3'd3;
        #1 check("bits_z3", z, 4'b1010);
        sel = 3'd6;
        #1 check("bits_z6", z, 4'b0110);
        step();

        repeat (400) begin
            for (int k = 0; k < 8; k++) d[k] = W'($urandom);
            sel   = 3'($urandom);
            rst_n = ($urandom_range(0, 15) != 0);
            #1 check("rand_z", z, d[sel]);
            if ($urandom_range(0, 3) == 0) begin
                sel = 3'($urandom);
                d[sel] = W'($urandom);
                #1 check("rand_z2", z, d[sel]);
            end
            step();
        end

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
